cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 The block SHALL have these ports: clk  input  1  clock, rising-edge active; reset  input  1  reset, asynchronous, active-high.
REQ-002 Cond  input  4  instruction condition field [31:28].
REQ-003 ALUFlags  input  4  {N,Z,C,V} from the ALU, valid in the execute/writeback cycle.
REQ-004 Decode  input  1  high for exactly the one DECODE cycle of each instruction; the condition is captured here.
REQ-005 FlagW  input  2  flag write request: [1] writes {N,Z}, [0] writes {C,V}.
REQ-006 PCS, NextPC, RegW, MemW  input  1 each  raw requests from the controller: PC-source, unconditional PC update, register write, memory write.
REQ-007 PCWrite, RegWrite, MemWrite  output  1 each  gated write enables.
REQ-008 Flags  output  4  architectural {N,Z,C,V} register.
REQ-009 CondEx  output  1  registered condition-passed bit for the current instruction.

Function
REQ-010 Condition evaluation SHALL use the current Flags register, not ALUFlags:
- 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
- 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
- 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
- 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 SHALL evaluate 0 (never).
REQ-011 CondEx SHALL load the evaluation result on the rising edge of clk when Decode=1, and SHALL hold its value otherwise.
REQ-012 RegWrite = RegW & CondEx, combinational.
REQ-013 MemWrite = MemW & CondEx, combinational.
REQ-014 PCWrite = NextPC | (PCS & CondEx), combinational; NextPC bypasses the condition so the fetch increment is never squashed.
REQ-015 Flags[3:2] SHALL load ALUFlags[3:2] on clk when FlagW[1] & CondEx.
REQ-016 Flags[1:0] SHALL load ALUFlags[1:0] on clk when FlagW[0] & CondEx.
REQ-017 Flags SHALL be unchanged when FlagW=00 or CondEx=0.
REQ-018 Decode=1 and FlagW≠00 in the same cycle:
- the flag update uses the pre-edge CondEx;
- the new CondEx is evaluated from the pre-edge Flags.
REQ-019 Latency: a flag write is visible to the condition evaluation on the cycle after the write edge.

Reset
REQ-020 While reset=1, Flags=0000 and CondEx=0; reset is asynchronous, and Flags and CondEx change on reset assertion without waiting for a clock edge.
REQ-021 Consequence of REQ-020: after reset RegWrite=MemWrite=0 and PCWrite=NextPC until the first Decode.
REQ-022 Reset asserted mid-instruction SHALL abort it; no pending write enable survives, except one driven by NextPC.

Configuration
REQ-023 Macro COND_PERF_EN SHALL control a squash counter:
- defined: adds output SquashCnt [15:0]; it increments on each Decode cycle whose evaluation is 0 and saturates at 16'hFFFF;
- reset clears SquashCnt to 0.
REQ-024 COND_PERF_EN undefined: the SquashCnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 Decode with Cond=0000, Flags.Z=1, then RegW=1 -> CondEx=1 and RegWrite=1 from the next cycle.
REQ-026 Decode with Cond=0000, Flags=0000, then RegW=1, MemW=1, PCS=1, NextPC=0 -> RegWrite=MemWrite=PCWrite=0.
REQ-027 Decode with Cond=1110, then FlagW=11 with ALUFlags=1010 -> Flags=1010 after the edge.
REQ-028 FlagW=10 with ALUFlags=0101 and CondEx=1 -> Flags[3:2]=01 and Flags[1:0] unchanged.
REQ-029 Decode with Cond=1111 repeated 70000 times with COND_PERF_EN defined -> SquashCnt=16'hFFFF and held there.
REQ-030 Reset asserted mid-cycle after Flags=1111 -> Flags=0000 and CondEx=0 immediately, before any clock edge; NextPC=1 -> PCWrite=1.

Source files
------------

// File: rtl/cond_unit.sv
// Conditional-execution unit: evaluates the condition field at decode, gates writes, and holds
// the architectural NZCV flags. Define COND_PERF_EN to add the saturating squash counter.
module cond_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  cond_i,
   input  logic [3:0]  alu_flags_i,
   input  logic        decode_i,
   input  logic [1:0]  flag_w_i,
   input  logic        pcs_i,
   input  logic        next_pc_i,
   input  logic        reg_w_i,
   input  logic        mem_w_i,
   output logic        pc_write_o,
   output logic        reg_write_o,
   output logic        mem_write_o,
   output logic [3:0]  flags_o,
   output logic        cond_ex_o
`ifdef COND_PERF_EN
   ,
   output logic [15:0] squash_cnt_o
`endif
);

   logic [3:0] flags_q, flags_d;
   logic       cond_ex_q, cond_ex_d;
   logic       cond_pass;

   // Flags are {N,Z,C,V}.
   function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      n  = f[3];
      z  = f[2];
      cf = f[1];
      v  = f[0];
      unique case (c)
         4'b0000: eval_cond = z;
         4'b0001: eval_cond = ~z;
         4'b0010: eval_cond = cf;
         4'b0011: eval_cond = ~cf;
         4'b0100: eval_cond = n;
         4'b0101: eval_cond = ~n;
         4'b0110: eval_cond = v;
         4'b0111: eval_cond = ~v;
         4'b1000: eval_cond = cf & ~z;
         4'b1001: eval_cond = ~cf | z;
         4'b1010: eval_cond = (n == v);
         4'b1011: eval_cond = (n != v);
         4'b1100: eval_cond = ~z & (n == v);
         4'b1101: eval_cond = z | (n != v);
         4'b1110: eval_cond = 1'b1;
         4'b1111: eval_cond = 1'b0;
      endcase
   endfunction

   always_comb begin
      cond_pass = eval_cond(cond_i, flags_q);
   end

   // Flag update is gated by the pre-edge cond_ex_q, so a decode in the same cycle cannot
   // influence the current instruction's flag write.
   always_comb begin
      flags_d = flags_q;
      if (flag_w_i[1] && cond_ex_q) begin
         flags_d[3:2] = alu_flags_i[3:2];
      end
      if (flag_w_i[0] && cond_ex_q) begin
         flags_d[1:0] = alu_flags_i[1:0];
      end
   end

   always_comb begin
      cond_ex_d = cond_ex_q;
      if (decode_i) begin
         cond_ex_d = cond_pass;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q   <= 4'b0000;
         cond_ex_q <= 1'b0;
      end else begin
         flags_q   <= flags_d;
         cond_ex_q <= cond_ex_d;
      end
   end

   // next_pc_i bypasses the condition so the fetch increment is never squashed.
   always_comb begin
      reg_write_o = reg_w_i & cond_ex_q;
      mem_write_o = mem_w_i & cond_ex_q;
      pc_write_o  = next_pc_i | (pcs_i & cond_ex_q);
      flags_o     = flags_q;
      cond_ex_o   = cond_ex_q;
   end

`ifdef COND_PERF_EN
   logic [15:0] squash_cnt_q, squash_cnt_d;

   always_comb begin
      squash_cnt_d = squash_cnt_q;
      if (decode_i && !cond_pass && (squash_cnt_q != 16'hFFFF)) begin
         squash_cnt_d = squash_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         squash_cnt_q <= 16'd0;
      end else begin
         squash_cnt_q <= squash_cnt_d;
      end
   end

   always_comb begin
      squash_cnt_o = squash_cnt_q;
   end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: directed vectors push expected outputs, a monitor compares.
module tb_cond_unit;

   logic       clk;
   logic       reset;
   logic [3:0] cond;
   logic [3:0] alu_flags;
   logic       decode;
   logic [1:0] flag_w;
   logic       pcs, next_pc, reg_w, mem_w;
   logic       pc_write, reg_write, mem_write;
   logic [3:0] flags;
   logic       cond_ex;
`ifdef COND_PERF_EN
   logic [15:0] squash_cnt;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [3:0] flags;
      logic       cex;
      logic       rw;
      logic       mw;
      logic       pw;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;

   cond_unit dut (
      .clk         (clk),
      .reset       (reset),
      .cond_i      (cond),
      .alu_flags_i (alu_flags),
      .decode_i    (decode),
      .flag_w_i    (flag_w),
      .pcs_i       (pcs),
      .next_pc_i   (next_pc),
      .reg_w_i     (reg_w),
      .mem_w_i     (mem_w),
      .pc_write_o  (pc_write),
      .reg_write_o (reg_write),
      .mem_write_o (mem_write),
      .flags_o     (flags),
      .cond_ex_o   (cond_ex)
`ifdef COND_PERF_EN
      ,
      .squash_cnt_o(squash_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: time limit expired, checks=%0d", checks);
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string nm, input string fld, input logic [15:0] act,
                      input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge, or after an asynchronous sample request.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or sample_ev);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.name, "flags", {12'd0, flags}, {12'd0, e.flags});
            cmp(e.name, "cond_ex", {15'd0, cond_ex}, {15'd0, e.cex});
            cmp(e.name, "reg_write", {15'd0, reg_write}, {15'd0, e.rw});
            cmp(e.name, "mem_write", {15'd0, mem_write}, {15'd0, e.mw});
            cmp(e.name, "pc_write", {15'd0, pc_write}, {15'd0, e.pw});
         end
      end
   end

   task automatic drive(input logic rst, input logic [3:0] c, input logic dec,
                        input logic [1:0] fw, input logic [3:0] alu, input logic p,
                        input logic np, input logic rw, input logic mw);
      reset     = rst;
      cond      = c;
      decode    = dec;
      flag_w    = fw;
      alu_flags = alu;
      pcs       = p;
      next_pc   = np;
      reg_w     = rw;
      mem_w     = mw;
   endtask

   task automatic push(input string nm, input logic [3:0] ef, input logic ecx,
                       input logic erw, input logic emw, input logic epw);
      exp_t e;
      e.name  = nm;
      e.flags = ef;
      e.cex   = ecx;
      e.rw    = erw;
      e.mw    = emw;
      e.pw    = epw;
      exp_q.push_back(e);
   endtask

   // One clocked vector: inputs set on the falling edge, expectation is post-rising-edge state.
   task automatic step(input string nm, input logic rst, input logic [3:0] c, input logic dec,
                       input logic [1:0] fw, input logic [3:0] alu, input logic p,
                       input logic np, input logic rw, input logic mw, input logic [3:0] ef,
                       input logic ecx, input logic erw, input logic emw, input logic epw);
      @(negedge clk);
      drive(rst, c, dec, fw, alu, p, np, rw, mw);
      push(nm, ef, ecx, erw, emw, epw);
   endtask

   initial begin
      drive(1'b1, 4'h0, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      //    name        rst cond   dec fw     alu    pcs  npc  rw   mw   flags  cex  rw   mw   pw
      step("reset",     1, 4'h0, 0, 2'b00, 4'h0, 1, 1, 1, 1, 4'h0, 0, 0, 0, 1);
      step("eq_fail",   0, 4'h0, 1, 2'b00, 4'h0, 1, 0, 1, 1, 4'h0, 0, 0, 0, 0);
      step("al_pass",   0, 4'hE, 1, 2'b00, 4'h0, 0, 0, 1, 0, 4'h0, 1, 1, 0, 0);
      step("fw11",      0, 4'h0, 0, 2'b11, 4'hA, 0, 0, 0, 1, 4'hA, 1, 0, 1, 0);
      step("fw10",      0, 4'h0, 0, 2'b10, 4'h5, 0, 0, 0, 0, 4'h6, 1, 0, 0, 0);
      step("eq_pass",   0, 4'h0, 1, 2'b00, 4'h0, 1, 0, 1, 0, 4'h6, 1, 1, 0, 1);
      step("dec_fw",    0, 4'h1, 1, 2'b11, 4'hF, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
      step("fw_gated",  0, 4'h0, 0, 2'b11, 4'h0, 1, 1, 1, 1, 4'hF, 0, 0, 0, 1);
      step("hi",        0, 4'h8, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
      step("ge",        0, 4'hA, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0);
      step("lt",        0, 4'hB, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
      step("gt",        0, 4'hC, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
      step("le",        0, 4'hD, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0);
      step("nv",        0, 4'hF, 1, 2'b00, 4'h0, 1, 0, 1, 1, 4'hF, 0, 0, 0, 0);
      step("vs",        0, 4'h6, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0);
      step("fw01",      0, 4'h0, 0, 2'b01, 4'h4, 0, 0, 0, 0, 4'hC, 1, 0, 0, 0);
      step("cc",        0, 4'h3, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'hC, 1, 0, 0, 0);
      step("pl",        0, 4'h5, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'hC, 0, 0, 0, 0);
      step("ls",        0, 4'h9, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'hC, 1, 0, 0, 0);
      step("mi",        0, 4'h4, 1, 2'b00, 4'h0, 0, 0, 1, 1, 4'hC, 1, 1, 1, 0);
      step("hold",      0, 4'hF, 0, 2'b00, 4'h0, 1, 0, 0, 0, 4'hC, 1, 0, 0, 1);
      step("set_f",     0, 4'h0, 0, 2'b11, 4'hF, 0, 0, 0, 0, 4'hF, 1, 0, 0, 0);

      // Asynchronous reset in the middle of an instruction's write cycle.
      @(negedge clk);
      drive(1'b0, 4'h0, 1'b0, 2'b11, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      #2;
      reset = 1'b1;
      push("async_rst", 4'h0, 0, 0, 0, 1);
      ->sample_ev;

      step("rst_dec",   1, 4'hE, 1, 2'b00, 4'h0, 1, 0, 1, 1, 4'h0, 0, 0, 0, 0);
      step("post_rst",  0, 4'hE, 0, 2'b00, 4'h0, 1, 1, 1, 1, 4'h0, 0, 0, 0, 1);
      step("ne",        0, 4'h1, 1, 2'b00, 4'h0, 0, 0, 1, 0, 4'h0, 1, 1, 0, 0);
      step("cs",        0, 4'h2, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
      step("vc",        0, 4'h7, 1, 2'b00, 4'h0, 1, 0, 0, 0, 4'h0, 1, 0, 0, 1);

      repeat (3) @(negedge clk);
      drive(1'b0, 4'h0, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

`ifdef COND_PERF_EN
      @(negedge clk);
      reset = 1'b1;
      #1;
      cmp("perf", "reset", squash_cnt, 16'd0);
      @(negedge clk);
      drive(1'b0, 4'hF, 1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      cmp("perf", "three", squash_cnt, 16'd3);
      decode = 1'b0;
      repeat (2) @(negedge clk);
      cmp("perf", "no_dec", squash_cnt, 16'd3);
      cond   = 4'hE;
      decode = 1'b1;
      repeat (2) @(negedge clk);
      cmp("perf", "pass", squash_cnt, 16'd3);
      cond = 4'hF;
      repeat (70000) @(posedge clk);
      @(negedge clk);
      cmp("perf", "sat", squash_cnt, 16'hFFFF);
      repeat (5) @(negedge clk);
      cmp("perf", "sat_hold", squash_cnt, 16'hFFFF);
      decode = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
